seg7_scan_mux: RTL and testbench

//   Time-multiplexed N-digit 7-segment driver; generalises the 3-way nibble selector.

---
 rtl/seg7_scan_mux_if.sv | 28 ++
 rtl/seg7_scan_mux.sv | 112 +++++++++++
 tb/tb_seg7_scan_mux.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for seg7_scan_mux: datapath nibbles and controls in,
// multiplexed anode/segment drive out.
interface seg7_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned IDX_W      = 2
);
    logic                    mode;
    logic [IDX_W-1:0]        sw;
    logic                    hold;
    logic [4*NUM_DIGITS-1:0] cnt_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cnt;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    tick;

    modport master (
        output mode, sw, hold, cnt_in, dp_in, blank,
        input  cnt, an, seg, dp, tick
    );

    modport slave (
        input  mode, sw, hold, cnt_in, dp_in, blank,
        output cnt, an, seg, dp, tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver: auto scan or manual select, with
// per-digit blanking and decimal point, all outputs registered and active-low.
module seg7_scan_mux #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned IDX_W      = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    seg7_scan_mux_if.slave bus_io
);
    localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PreW-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick;

    logic [3:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [3:0]            nib;
    logic                  sel_dp, sel_blank, idx_valid;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = !bus_io.hold && (presc_q == PreW'(DIV - 1));
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!bus_io.hold) begin
            presc_d = tick ? '0 : presc_q + PreW'(1);
            if (bus_io.mode) begin
                idx_d = bus_io.sw;
            end else if (tick) begin
                // An out-of-range index left over from manual mode also wraps to 0.
                idx_d = (32'(idx_q) >= NUM_DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        nib       = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        idx_valid = 1'b0;
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = bus_io.cnt_in[4*i +: 4];
                sel_dp    = bus_io.dp_in[i];
                sel_blank = bus_io.blank[i];
                idx_valid = 1'b1;
                an_d[i]   = 1'b0;
            end
        end
        cnt_d = nib;
        seg_d = ~hex7(nib);
        dp_d  = ~sel_dp;
        if (sel_blank || !idx_valid) begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            idx_q   <= '0;
            cnt_q   <= 4'h0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus_io.cnt  = cnt_q;
    assign bus_io.an   = an_q;
    assign bus_io.seg  = seg_q;
    assign bus_io.dp   = dp_q;
    assign bus_io.tick = tick;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux with 3 digits and a 4-cycle slot.
module tb_seg7_scan_mux;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seg7_scan_mux_if #(.NUM_DIGITS(3), .IDX_W(2)) bus ();

    seg7_scan_mux #(.NUM_DIGITS(3), .DIV(4), .IDX_W(2)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Expected per-slot values for CNT_IN = 12'h3CA.
    localparam logic [2:0] AnTab  [3] = '{3'b110, 3'b101, 3'b011};
    localparam logic [3:0] CntTab [3] = '{4'hA, 4'hC, 4'h3};
    localparam logic [6:0] SegTab [3] = '{7'h08, 7'h46, 7'h30};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.mode = 1'b0; bus.sw = 2'd0; bus.hold = 1'b0;
        bus.cnt_in = 12'h3CA; bus.dp_in = 3'b000; bus.blank = 3'b000;
        rst = 1'b1;
        repeat (2) step();
        checks++; if (bus.an !== 3'b111) begin $display("FAIL reset_an got=%b exp=111", bus.an); errors++; end
        checks++; if (bus.seg !== 7'h7F) begin $display("FAIL reset_seg got=%h exp=7f", bus.seg); errors++; end
        checks++; if (bus.dp !== 1'b1) begin $display("FAIL reset_dp got=%b exp=1", bus.dp); errors++; end
        checks++; if (bus.cnt !== 4'h0) begin $display("FAIL reset_cnt got=%h exp=0", bus.cnt); errors++; end
        checks++; if (bus.tick !== 1'b0) begin $display("FAIL reset_tick got=%b exp=0", bus.tick); errors++; end
        rst = 1'b0;
    endtask

    task automatic test_auto_scan();
        int slot;
        logic exp_tick;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            slot = (k - 1) / 4;
            exp_tick = ((k % 4) == 3);
            checks++; if (bus.an !== AnTab[slot]) begin $display("FAIL auto_an k=%0d got=%b exp=%b", k, bus.an, AnTab[slot]); errors++; end
            checks++; if (bus.cnt !== CntTab[slot]) begin $display("FAIL auto_cnt k=%0d got=%h exp=%h", k, bus.cnt, CntTab[slot]); errors++; end
            checks++; if (bus.seg !== SegTab[slot]) begin $display("FAIL auto_seg k=%0d got=%h exp=%h", k, bus.seg, SegTab[slot]); errors++; end
            checks++; if (bus.dp !== 1'b1) begin $display("FAIL auto_dp k=%0d got=%b exp=1", k, bus.dp); errors++; end
            checks++; if (bus.tick !== exp_tick) begin $display("FAIL auto_tick k=%0d got=%b exp=%b", k, bus.tick, exp_tick); errors++; end
        end
    endtask

    task automatic test_manual();
        int ticks;
        bit found;
        do_reset();
        bus.mode = 1'b1; bus.sw = 2'd2;
        step(); step();
        checks++; if (bus.an !== 3'b011) begin $display("FAIL man_an got=%b exp=011", bus.an); errors++; end
        checks++; if (bus.cnt !== 4'h3) begin $display("FAIL man_cnt got=%h exp=3", bus.cnt); errors++; end
        checks++; if (bus.seg !== 7'h30) begin $display("FAIL man_seg got=%h exp=30", bus.seg); errors++; end
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 1) begin $display("FAIL man_ticks got=%0d exp=1", ticks); errors++; end
        bus.sw = 2'd3;
        step(); step();
        checks++; if (bus.an !== 3'b111) begin $display("FAIL man_inv_an got=%b exp=111", bus.an); errors++; end
        checks++; if (bus.seg !== 7'h7F) begin $display("FAIL man_inv_seg got=%h exp=7f", bus.seg); errors++; end
        checks++; if (bus.dp !== 1'b1) begin $display("FAIL man_inv_dp got=%b exp=1", bus.dp); errors++; end
        bus.sw = 2'd1;
        step(); step();
        checks++; if (bus.an !== 3'b101) begin $display("FAIL man_sw1_an got=%b exp=101", bus.an); errors++; end
        bus.mode = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.tick === 1'b1) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin $display("FAIL resume_tick got=none exp=tick within 8 cycles"); errors++; end
        step(); step();
        checks++; if (bus.an !== 3'b011) begin $display("FAIL resume_an got=%b exp=011", bus.an); errors++; end
        checks++; if (bus.cnt !== 4'h3) begin $display("FAIL resume_cnt got=%h exp=3", bus.cnt); errors++; end
        bus.sw = 2'd0;
    endtask

    task automatic test_blank_dp();
        bus.blank = 3'b010; bus.dp_in = 3'b001;
        do_reset();
        step();
        checks++; if (bus.an !== 3'b110) begin $display("FAIL bd_d0_an got=%b exp=110", bus.an); errors++; end
        checks++; if (bus.dp !== 1'b0) begin $display("FAIL bd_d0_dp got=%b exp=0", bus.dp); errors++; end
        checks++; if (bus.seg !== 7'h08) begin $display("FAIL bd_d0_seg got=%h exp=08", bus.seg); errors++; end
        repeat (4) step();
        checks++; if (bus.an !== 3'b111) begin $display("FAIL bd_d1_an got=%b exp=111", bus.an); errors++; end
        checks++; if (bus.seg !== 7'h7F) begin $display("FAIL bd_d1_seg got=%h exp=7f", bus.seg); errors++; end
        checks++; if (bus.dp !== 1'b1) begin $display("FAIL bd_d1_dp got=%b exp=1", bus.dp); errors++; end
        checks++; if (bus.cnt !== 4'hC) begin $display("FAIL bd_d1_cnt got=%h exp=c", bus.cnt); errors++; end
        repeat (4) step();
        checks++; if (bus.an !== 3'b011) begin $display("FAIL bd_d2_an got=%b exp=011", bus.an); errors++; end
        checks++; if (bus.dp !== 1'b1) begin $display("FAIL bd_d2_dp got=%b exp=1", bus.dp); errors++; end
        bus.blank = 3'b000; bus.dp_in = 3'b000;
    endtask

    task automatic test_hold();
        do_reset();
        repeat (5) step();
        bus.hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (bus.tick !== 1'b0) begin $display("FAIL hold_tick i=%0d got=%b exp=0", i, bus.tick); errors++; end
            checks++; if (bus.an !== 3'b101) begin $display("FAIL hold_an i=%0d got=%b exp=101", i, bus.an); errors++; end
        end
        bus.cnt_in = 12'h3DA;
        step();
        checks++; if (bus.cnt !== 4'hD) begin $display("FAIL hold_live_cnt got=%h exp=d", bus.cnt); errors++; end
        checks++; if (bus.seg !== 7'h21) begin $display("FAIL hold_live_seg got=%h exp=21", bus.seg); errors++; end
        bus.cnt_in = 12'h3CA;
        bus.hold = 1'b0;
        step();
        checks++; if (bus.tick !== 1'b0) begin $display("FAIL unhold_tick1 got=%b exp=0", bus.tick); errors++; end
        step();
        checks++; if (bus.tick !== 1'b1) begin $display("FAIL unhold_tick2 got=%b exp=1", bus.tick); errors++; end
        step();
        checks++; if (bus.an !== 3'b101) begin $display("FAIL unhold_an1 got=%b exp=101", bus.an); errors++; end
        step();
        checks++; if (bus.an !== 3'b011) begin $display("FAIL unhold_an2 got=%b exp=011", bus.an); errors++; end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        repeat (10) step();
        checks++; if (bus.an !== 3'b011) begin $display("FAIL mid_pre_an got=%b exp=011", bus.an); errors++; end
        rst = 1'b1;
        step();
        checks++; if (bus.an !== 3'b111) begin $display("FAIL mid_rst_an got=%b exp=111", bus.an); errors++; end
        checks++; if (bus.tick !== 1'b0) begin $display("FAIL mid_rst_tick got=%b exp=0", bus.tick); errors++; end
        rst = 1'b0;
        step();
        checks++; if (bus.an !== 3'b110) begin $display("FAIL mid_e1_an got=%b exp=110", bus.an); errors++; end
        checks++; if (bus.tick !== 1'b0) begin $display("FAIL mid_e1_tick got=%b exp=0", bus.tick); errors++; end
        step();
        checks++; if (bus.tick !== 1'b0) begin $display("FAIL mid_e2_tick got=%b exp=0", bus.tick); errors++; end
        step();
        checks++; if (bus.tick !== 1'b1) begin $display("FAIL mid_e3_tick got=%b exp=1", bus.tick); errors++; end
        step(); step();
        checks++; if (bus.an !== 3'b101) begin $display("FAIL mid_e5_an got=%b exp=101", bus.an); errors++; end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_auto_scan();
        test_manual();
        test_blank_dp();
        test_hold();
        test_reset_mid_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
